dotprod_stream: RTL and testbench

//  Parametrised streaming dot-product engine; the next generation of the fixed 8x32-bit dotprod.

---
 rtl/dotprod_stream_if.sv | 31 +++
 rtl/dotprod_stream.sv | 134 +++++++++++++
 tb/tb_dotprod_stream.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/dotprod_stream_if.sv
// rtl/dotprod_stream_if.sv - operand/control/result bundle for dotprod_stream
// master drives operands and control, slave is the dot-product engine.
interface dotprod_stream_if #(
  parameter int DATA_W  = 32,
  parameter int VEC_LEN = 8,
  parameter int LANES   = 1
);
  localparam int ACC_W = 2 * DATA_W + $clog2(VEC_LEN) + 1;

  logic                    start;
  logic                    mode_signed;
  logic                    acc_keep;
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*DATA_W-1:0] in_a;
  logic [LANES*DATA_W-1:0] in_b;
  logic                    busy;
  logic                    done;
  logic [ACC_W-1:0]        result;
  logic                    overflow;

  modport master (
    output start, mode_signed, acc_keep, in_valid, in_a, in_b,
    input  in_ready, busy, done, result, overflow
  );

  modport slave (
    input  start, mode_signed, acc_keep, in_valid, in_a, in_b,
    output in_ready, busy, done, result, overflow
  );
endinterface

// File: rtl/dotprod_stream.sv
// rtl/dotprod_stream.sv - pipelined streaming dot-product engine
// LANES element pairs per beat; stage 1 sums lane products, stage 2 accumulates.
module dotprod_stream #(
  parameter int DATA_W  = 32,
  parameter int VEC_LEN = 8,
  parameter int LANES   = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  dotprod_stream_if.slave bus
);
  localparam int ACC_W = 2 * DATA_W + $clog2(VEC_LEN) + 1;
  localparam int BEATS = VEC_LEN / LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int EXT_W = ACC_W - DATA_W;

  if ((VEC_LEN % LANES) != 0 || !(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_params
    $error("dotprod_stream: LANES must be 1/2/4/8 and divide VEC_LEN");
  end

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_signed;
  logic               r_in_ready;
  logic               r_busy;
  logic               r_done;
  logic               r_pvalid;
  logic               r_overflow;
  logic [ACC_W-1:0]   r_prod;
  logic [ACC_W-1:0]   r_acc;

  logic               w_accept;
  logic               w_last;
  logic [DATA_W-1:0]  w_la;
  logic [DATA_W-1:0]  w_lb;
  logic [ACC_W-1:0]   w_ea;
  logic [ACC_W-1:0]   w_eb;
  logic [ACC_W-1:0]   w_prod_sum;
  logic [ACC_W-1:0]   w_sum;
  logic               w_carry;
  logic               w_add_ovf;

  assign w_accept = bus.in_valid && r_in_ready;
  assign w_last   = (r_cnt == CNT_W'(BEATS - 1));

  // Operands are extended to ACC_W before multiplying so the truncated product is exact modulo 2^ACC_W.
  always_comb begin
    w_prod_sum = '0;
    w_la       = '0;
    w_lb       = '0;
    w_ea       = '0;
    w_eb       = '0;
    for (int i = 0; i < LANES; i++) begin
      w_la       = bus.in_a[i*DATA_W +: DATA_W];
      w_lb       = bus.in_b[i*DATA_W +: DATA_W];
      w_ea       = {{EXT_W{r_signed & w_la[DATA_W-1]}}, w_la};
      w_eb       = {{EXT_W{r_signed & w_lb[DATA_W-1]}}, w_lb};
      w_prod_sum = w_prod_sum + w_ea * w_eb;
    end
  end

  assign {w_carry, w_sum} = {1'b0, r_acc} + {1'b0, r_prod};
  assign w_add_ovf = r_signed
                   ? ((r_acc[ACC_W-1] == r_prod[ACC_W-1]) && (w_sum[ACC_W-1] != r_acc[ACC_W-1]))
                   : w_carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_signed   <= 1'b0;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pvalid   <= 1'b0;
      r_overflow <= 1'b0;
      r_prod     <= '0;
      r_acc      <= '0;
    end else begin
      r_done   <= 1'b0;
      r_pvalid <= w_accept;
      if (w_accept) r_prod <= w_prod_sum;
      if (r_pvalid) begin
        r_acc <= w_sum;
        if (w_add_ovf) r_overflow <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state    <= S_LOAD;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
            r_signed   <= bus.mode_signed;
            r_cnt      <= '0;
            if (!bus.acc_keep) begin
              r_acc      <= '0;
              r_overflow <= 1'b0;
            end
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            if (w_last) begin
              r_state    <= S_FLUSH;
              r_in_ready <= 1'b0;
              r_cnt      <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        S_FLUSH: begin
          // Last product is being added this edge, so the result is final with done.
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready = r_in_ready;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.result   = r_acc;
  assign bus.overflow = r_overflow;
endmodule

// File: tb/tb_dotprod_stream.sv
// tb/tb_dotprod_stream.sv - scoreboard bench for dotprod_stream
// Three instances: defaults, LANES=2, and a narrow DATA_W=4/VEC_LEN=2 build for wrap cases.
module tb_dotprod_stream;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dotprod_stream_if #(.DATA_W(32), .VEC_LEN(8), .LANES(1)) if0 ();
  dotprod_stream_if #(.DATA_W(32), .VEC_LEN(8), .LANES(2)) if1 ();
  dotprod_stream_if #(.DATA_W(4),  .VEC_LEN(2), .LANES(1)) if2 ();

  dotprod_stream #(.DATA_W(32), .VEC_LEN(8), .LANES(1)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  dotprod_stream #(.DATA_W(32), .VEC_LEN(8), .LANES(2)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  dotprod_stream #(.DATA_W(4),  .VEC_LEN(2), .LANES(1)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  typedef struct {
    logic [67:0] res;
    logic        ovf;
    int          edges;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] va[8];
  logic [31:0] vb[8];

  task automatic check(input string tag, input logic [67:0] obs, input logic [67:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [67:0] model(input bit sgn);
    logic [67:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      if (sgn) s = s + 68'($signed(va[i])) * 68'($signed(vb[i]));
      else     s = s + 68'(va[i]) * 68'(vb[i]);
    end
    return s;
  endfunction

  task automatic push_exp(input logic [67:0] res, input bit ovf, input int edges);
    exp_t e;
    e.res = res; e.ovf = ovf; e.edges = edges;
    sb.push_back(e);
  endtask

  task automatic sb_check(input string tag, input logic d, input int edges, input logic [67:0] res,
                          input logic ovf, input logic bsy, input logic rdy);
    exp_t e;
    e = sb.pop_front();
    check({tag, "_done"}, 68'(d), 68'(1));
    check({tag, "_latency"}, 68'(edges), 68'(e.edges));
    check({tag, "_result"}, res, e.res);
    check({tag, "_overflow"}, 68'(ovf), 68'(e.ovf));
    check({tag, "_busy_idle"}, 68'(bsy), 68'(0));
    check({tag, "_ready_idle"}, 68'(rdy), 68'(0));
  endtask

  // Called at a negedge; returns at the negedge where done is seen (or the budget runs out).
  task automatic run0(input bit sgn, input bit keep, input bit stall, input bit poke,
                      input logic [67:0] exp_res, input bit exp_ovf, input int exp_edges, input string tag);
    int  edges;
    int  k;
    int  stall_left;
    bit  acc_ok;
    push_exp(exp_res, exp_ovf, exp_edges);
    if0.start = 1'b1; if0.mode_signed = sgn; if0.acc_keep = keep; if0.in_valid = 1'b0;
    @(posedge clk); edges = 0;
    @(negedge clk);
    if0.start = poke;
    if0.mode_signed = ~sgn;
    if0.acc_keep = ~keep;
    check({tag, "_done_pulse_end"}, 68'(if0.done), 68'(0));
    check({tag, "_busy_load"}, 68'(if0.busy), 68'(1));
    k = 0; stall_left = 0;
    while (k < 8 && edges < 60) begin
      if0.in_valid = (stall_left == 0);
      if0.in_a = va[k]; if0.in_b = vb[k];
      acc_ok = if0.in_valid && if0.in_ready;
      @(posedge clk); edges++;
      @(negedge clk);
      if (acc_ok) begin
        k++;
        if (stall && (k == 2 || k == 5)) stall_left = 3;
      end else if (stall_left > 0) begin
        stall_left--;
      end
    end
    if0.in_valid = 1'b0; if0.start = 1'b0; if0.in_a = '1; if0.in_b = '1;
    while (!if0.done && edges < 60) begin
      @(posedge clk); edges++;
      @(negedge clk);
    end
    sb_check(tag, if0.done, edges, if0.result, if0.overflow, if0.busy, if0.in_ready);
  endtask

  task automatic run1(input logic [67:0] exp_res, input string tag);
    int edges;
    int k;
    bit acc_ok;
    push_exp(exp_res, 1'b0, 5);
    if1.start = 1'b1; if1.mode_signed = 1'b0; if1.acc_keep = 1'b0;
    @(posedge clk); edges = 0;
    @(negedge clk); if1.start = 1'b0;
    k = 0;
    while (k < 4 && edges < 40) begin
      if1.in_valid = 1'b1;
      if1.in_a = {va[2*k+1], va[2*k]}; if1.in_b = {vb[2*k+1], vb[2*k]};
      acc_ok = if1.in_ready;
      @(posedge clk); edges++;
      @(negedge clk);
      if (acc_ok) k++;
    end
    if1.in_valid = 1'b0;
    while (!if1.done && edges < 40) begin
      @(posedge clk); edges++;
      @(negedge clk);
    end
    sb_check(tag, if1.done, edges, 68'(if1.result), if1.overflow, if1.busy, if1.in_ready);
  endtask

  task automatic run2(input bit keep, input logic [9:0] exp_res, input bit exp_ovf, input string tag);
    int edges;
    int k;
    bit acc_ok;
    push_exp(68'(exp_res), exp_ovf, 3);
    if2.start = 1'b1; if2.mode_signed = 1'b0; if2.acc_keep = keep;
    @(posedge clk); edges = 0;
    @(negedge clk); if2.start = 1'b0;
    k = 0;
    while (k < 2 && edges < 40) begin
      if2.in_valid = 1'b1; if2.in_a = 4'd15; if2.in_b = 4'd15;
      acc_ok = if2.in_ready;
      @(posedge clk); edges++;
      @(negedge clk);
      if (acc_ok) k++;
    end
    if2.in_valid = 1'b0;
    while (!if2.done && edges < 40) begin
      @(posedge clk); edges++;
      @(negedge clk);
    end
    sb_check(tag, if2.done, edges, 68'(if2.result), if2.overflow, if2.busy, if2.in_ready);
  endtask

  initial begin
    if0.start = 0; if0.mode_signed = 0; if0.acc_keep = 0; if0.in_valid = 0; if0.in_a = '0; if0.in_b = '0;
    if1.start = 0; if1.mode_signed = 0; if1.acc_keep = 0; if1.in_valid = 0; if1.in_a = '0; if1.in_b = '0;
    if2.start = 0; if2.mode_signed = 0; if2.acc_keep = 0; if2.in_valid = 0; if2.in_a = '0; if2.in_b = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 68'(if0.in_ready), 68'(0));
    check("rst_busy", 68'(if0.busy), 68'(0));
    check("rst_done", 68'(if0.done), 68'(0));
    check("rst_result", if0.result, 68'(0));
    check("rst_overflow", 68'(if0.overflow), 68'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_not_ready", 68'(if0.in_ready), 68'(0));

    for (int i = 0; i < 8; i++) begin va[i] = 32'(i + 1); vb[i] = 32'(8 - i); end
    run0(0, 0, 0, 0, 68'd120, 0, 9,  "t1_basic");
    run0(0, 1, 0, 0, 68'd240, 0, 9,  "t5_keep");
    run0(0, 0, 0, 0, 68'd120, 0, 9,  "t5_clear");
    run0(0, 0, 1, 1, 68'd120, 0, 15, "t4_stall");
    run1(68'd120, "t2_lanes2");

    for (int i = 0; i < 8; i++) begin va[i] = 32'hFFFF_FFFF; vb[i] = 32'd3; end
    run0(1, 0, 0, 0, 68'd0 - 68'd24, 0, 9, "t3_signed");

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 8; i++) begin va[i] = $urandom; vb[i] = $urandom; end
      run0(r[0], 0, 0, 0, model(r[0]), 0, 9, "rnd");
    end
    for (int i = 0; i < 8; i++) begin va[i] = $urandom; vb[i] = $urandom; end
    run1(model(0), "rnd_lanes2");

    run2(0, 10'd450, 0, "t6_run1");
    run2(1, 10'd900, 0, "t6_keep2");
    run2(1, 10'd326, 1, "t6_wrap");
    run2(1, 10'd776, 1, "t6_sticky");
    run2(0, 10'd450, 0, "t6_clear");

    if2.start = 1'b1; if2.acc_keep = 1'b1;
    @(negedge clk);
    if2.start = 1'b0; if2.in_valid = 1'b1; if2.in_a = 4'd15; if2.in_b = 4'd15;
    repeat (2) @(negedge clk);
    check("mid_busy_before_rst", 68'(if2.busy), 68'(1));
    rst_n = 1'b0;
    #1;
    check("async_rst_result", 68'(if2.result), 68'(0));
    check("async_rst_busy", 68'(if2.busy), 68'(0));
    check("async_rst_ready", 68'(if2.in_ready), 68'(0));
    check("async_rst_overflow", 68'(if2.overflow), 68'(0));
    check("async_rst_result0", if0.result, 68'(0));
    check("scoreboard_empty", 68'(sb.size()), 68'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
